// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction fetch unit: issues word fetches over a req/ack port and queues
// {pc, instruction} pairs in a small FIFO that the core drains; a redirect flushes and restarts.
module instruction_prefetch_buffer #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_data,
  output logic [31:0] fetch_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_address,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  debug_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   next_pc_q;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          ack_fire;
  logic          push;
  logic          pop;
  logic          room;
  logic [31:0]   redirect_pc;
  logic [31:0]   pc_plus4;

  // Handshakes: a memory transfer completes on mem_req && mem_ack (mem_req/mem_address held
  // until then); a core transfer completes on fetch_valid && fetch_ready. Redirect cancels both.
  assign ack_fire    = mem_req_q & mem_ack;
  assign push        = (state_q == ST_REQ) & ack_fire & ~redirect;
  assign fetch_valid = (count_q != '0);
  assign pop         = fetch_valid & fetch_ready & ~redirect;
  assign redirect_pc = {redirect_address[31:2], 2'b00};
  assign pc_plus4    = next_pc_q + 32'd4;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Looking at the post-pop occupancy lets a full FIFO that is popped re-request immediately.
  assign room = (count_d < DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= BOOT_ADDRESS;
        data_mem_q[i] <= 32'h0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= next_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign fetch_pc   = pc_mem_q[rd_ptr_q];
  assign fetch_data = data_mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= BOOT_ADDRESS;
      next_pc_q  <= BOOT_ADDRESS;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            next_pc_q  <= redirect_pc;
            mem_addr_q <= redirect_pc;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REQ;
          end else if (room) begin
            mem_addr_q <= next_pc_q;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (redirect) begin
            next_pc_q <= redirect_pc;
            if (ack_fire) begin
              mem_addr_q <= redirect_pc;
            end else begin
              // The unacked request must still complete; its data will be thrown away.
              state_q <= ST_DRAIN;
            end
          end else if (ack_fire) begin
            next_pc_q <= pc_plus4;
            if (room) begin
              mem_addr_q <= pc_plus4;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (redirect) next_pc_q <= redirect_pc;
          if (ack_fire) begin
            mem_addr_q <= redirect ? redirect_pc : next_pc_q;
            state_q    <= ST_REQ;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_address = mem_addr_q;
  assign debug_state = state_q;

  always_ff @(posedge clk) begin
    if (reset && push) assert (count_q != DEPTH_C);
  end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed bench for instruction_prefetch_buffer: a memory responder, directed scenarios, and a
// monitor that pops an expected {pc, data} queue whenever the core side accepts a word.
module tb_instruction_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;
  logic        redirect;
  logic [31:0] redirect_address;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  debug_state;

  logic        ack_en;
  logic        force_en;
  logic [31:0] force_val;

  logic [63:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          ack_cnt     = 0;

  instruction_prefetch_buffer #(
    .BOOT_ADDRESS(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_data(fetch_data),
    .fetch_pc(fetch_pc),
    .redirect(redirect),
    .redirect_address(redirect_address),
    .mem_req(mem_req),
    .mem_address(mem_address),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .debug_state(debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // memory responder
  always_comb begin
    mem_ack   = ack_en;
    mem_rdata = force_en ? force_val : word_of(mem_address);
  end

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_q.push_back({pc, word_of(pc)});
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected words never delivered", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic hold_reset();
    reset       = 1'b0;
    ack_en      = 1'b0;
    fetch_ready = 1'b0;
    redirect    = 1'b0;
    redirect_address = 32'h0;
    force_en    = 1'b0;
    force_val   = 32'h0;
    exp_q.delete();
    step(2);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && mem_req && mem_ack) ack_cnt++;
    if (reset && fetch_valid && fetch_ready && !redirect && exp_q.size() != 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      vectors++;
      if ({fetch_pc, fetch_data} !== e) begin
        miscompares++;
        $display("FAIL fetch_entry: got pc=%h data=%h expected pc=%h data=%h",
                 fetch_pc, fetch_data, e[63:32], e[31:0]);
      end
    end
  end

  initial begin
    // reset values
    hold_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_data", fetch_data, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);

    // 1: streaming, one word per cycle
    ack_en = 1'b1;
    fetch_ready = 1'b1;
    for (int k = 0; k < 8; k++) expect_word(32'(k * 4));
    reset = 1'b1;
    step(1);
    for (int k = 0; k < 8; k++) begin
      check("t1_mem_req", mem_req, 1);
      check("t1_mem_address", mem_address, 32'(k * 4));
      if (k == 0) check("t1_first_latency_empty", fetch_valid, 0);
      if (k == 1) check("t1_first_latency_valid", fetch_valid, 1);
      step(1);
    end
    wait_empty("t1_stream");

    // 2: fill to DEPTH, then a single pop reopens fetching at 0x10
    hold_reset();
    ack_en = 1'b1;
    ack_cnt = 0;
    reset = 1'b1;
    step(5);
    check("t2_full_mem_req", mem_req, 0);
    check("t2_full_valid", fetch_valid, 1);
    step(3);
    check("t2_idle_mem_req", mem_req, 0);
    check("t2_ack_count", ack_cnt, 4);
    expect_word(32'h0);
    fetch_ready = 1'b1;
    step(1);
    fetch_ready = 1'b0;
    check("t2_reopen_req", mem_req, 1);
    check("t2_reopen_addr", mem_address, 32'h10);
    step(1);
    ack_en = 1'b0;
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    expect_word(32'h10);
    fetch_ready = 1'b1;
    wait_empty("t2_drain_fifo");

    // 3: redirect while a request is pending -> drain, dropped data
    hold_reset();
    fetch_ready = 1'b1;
    reset = 1'b1;
    step(1);
    redirect = 1'b1;
    redirect_address = 32'h8;
    step(1);
    redirect = 1'b0;
    ack_en = 1'b1;
    check("t3_pre_drain_addr", mem_address, 32'h0);
    step(1);
    ack_en = 1'b0;
    check("t3_pending_addr", mem_address, 32'h8);
    redirect = 1'b1;
    redirect_address = 32'h103;
    step(1);
    redirect = 1'b0;
    expect_word(32'h100);
    expect_word(32'h104);
    check("t3_drain_addr_c1", mem_address, 32'h8);
    check("t3_drain_req_c1", mem_req, 1);
    check("t3_drain_valid_c1", fetch_valid, 0);
    step(1);
    check("t3_drain_addr_c2", mem_address, 32'h8);
    step(1);
    check("t3_drain_addr_c3", mem_address, 32'h8);
    force_en = 1'b1;
    force_val = 32'hDEAD_BEEF;
    ack_en = 1'b1;
    step(1);
    force_en = 1'b0;
    check("t3_restart_addr", mem_address, 32'h100);
    check("t3_dropped_valid", fetch_valid, 0);
    step(2);
    ack_en = 1'b0;
    wait_empty("t3_restart");

    // 4: redirect in the same cycle as an ack -> no drain cycle
    hold_reset();
    ack_en = 1'b1;
    reset = 1'b1;
    step(3);
    redirect = 1'b1;
    redirect_address = 32'h200;
    step(1);
    redirect = 1'b0;
    check("t4_addr", mem_address, 32'h200);
    check("t4_req", mem_req, 1);
    check("t4_valid_cleared", fetch_valid, 0);
    expect_word(32'h200);
    expect_word(32'h204);
    fetch_ready = 1'b1;
    step(1);
    check("t4_no_drain_addr", mem_address, 32'h204);
    check("t4_valid", fetch_valid, 1);
    wait_empty("t4_stream");

    // 5: full FIFO, redirect together with a pop
    hold_reset();
    ack_en = 1'b1;
    reset = 1'b1;
    step(5);
    check("t5_full_valid", fetch_valid, 1);
    fetch_ready = 1'b1;
    redirect = 1'b1;
    redirect_address = 32'h300;
    step(1);
    redirect = 1'b0;
    fetch_ready = 1'b0;
    check("t5_valid_cleared", fetch_valid, 0);
    check("t5_addr", mem_address, 32'h300);
    expect_word(32'h300);
    expect_word(32'h304);
    expect_word(32'h308);
    fetch_ready = 1'b1;
    wait_empty("t5_no_duplicates");

    // 6: reset asserted mid-request
    hold_reset();
    ack_en = 1'b1;
    reset = 1'b1;
    step(2);
    check("t6_pre_valid", fetch_valid, 1);
    reset = 1'b0;
    #1;
    check("t6_async_req", mem_req, 0);
    check("t6_async_valid", fetch_valid, 0);
    check("t6_async_addr", mem_address, 32'h0);
    step(1);
    fetch_ready = 1'b1;
    expect_word(32'h0);
    expect_word(32'h4);
    reset = 1'b1;
    step(1);
    check("t6_refetch_addr", mem_address, 32'h0);
    wait_empty("t6_refetch");

    // 7: unaligned redirect near the top of memory, pc wraps to zero
    redirect = 1'b1;
    redirect_address = 32'hFFFF_FFF9;
    step(1);
    redirect = 1'b0;
    check("t7_aligned_addr", mem_address, 32'hFFFF_FFF8);
    expect_word(32'hFFFF_FFF8);
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    wait_empty("t7_wrap");

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
